gfx_mem_arbiter: RTL and testbench

- Shares the DDR address FIFO (af) and write-data FIFO (wdf) write ports between NUM_REQ graphics write engines, e.g. the line engine and the fill engine.
- Every engine writes in bursts of one af command plus BURST_WORDS wdf words. The arbiter grants whole bursts atomically, so commands and data from different engines never interleave.
- Grants rotate round-robin between requesters.
- The arbiter sits between the engines and the af/wdf FIFO inputs.

---
 rtl/gfx_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_gfx_mem_arbiter.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter sharing the DDR af/wdf write ports between
// graphics write engines; one burst (1 af + BURST_WORDS wdf) per grant.
module gfx_mem_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 31,
   parameter int BURST_WORDS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_af_addr_din,
   input  logic [NUM_REQ-1:0]        req_af_wr_en,
   input  logic [NUM_REQ*128-1:0]    req_wdf_din,
   input  logic [NUM_REQ*16-1:0]     req_wdf_mask_din,
   input  logic [NUM_REQ-1:0]        req_wdf_wr_en,
   output logic [NUM_REQ-1:0]        req_af_full,
   output logic [NUM_REQ-1:0]        req_wdf_full,
   input  logic                      af_full,
   input  logic                      wdf_full,
   output logic [ADDR_W-1:0]         af_addr_din,
   output logic                      af_wr_en,
   output logic [127:0]              wdf_din,
   output logic [15:0]               wdf_mask_din,
   output logic                      wdf_wr_en,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_WORDS);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             af_done;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             af_acc;
   logic             wdf_acc;
   logic             af_nxt;
   logic             done;
   logic             in_burst;

   assign in_burst = (state == BURST);

   // first requester at or after rr_ptr, wrapping
   always_comb begin
      pick  = rr_ptr;
      cand  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      af_addr_din  = '0;
      wdf_din      = '0;
      wdf_mask_din = '0;
      af_wr_en     = 1'b0;
      wdf_wr_en    = 1'b0;
      req_af_full  = '1;
      req_wdf_full = '1;
      if (in_burst) begin
         af_addr_din  = req_af_addr_din[int'(gnt_idx)*ADDR_W +: ADDR_W];
         wdf_din      = req_wdf_din[int'(gnt_idx)*128 +: 128];
         wdf_mask_din = req_wdf_mask_din[int'(gnt_idx)*16 +: 16];
         af_wr_en     = req_af_wr_en[gnt_idx] & ~af_done;
         wdf_wr_en    = req_wdf_wr_en[gnt_idx] & (wd_cnt < CNT_MAX);
         req_af_full[gnt_idx]  = af_full | af_done;
         req_wdf_full[gnt_idx] = wdf_full | (wd_cnt == CNT_MAX);
      end
   end

   assign af_acc  = af_wr_en & ~af_full;
   assign wdf_acc = wdf_wr_en & ~wdf_full;
   assign af_nxt  = af_done | af_acc;
   assign cnt_nxt = wd_cnt + CNT_W'(wdf_acc);
   assign done    = af_nxt & (cnt_nxt == CNT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         gnt_idx <= '0;
         rr_ptr  <= '0;
         af_done <= 1'b0;
         wd_cnt  <= '0;
         grant   <= '0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  state   <= BURST;
                  gnt_idx <= pick;
                  grant   <= NUM_REQ'(1) << pick;
                  busy    <= 1'b1;
               end
            end
            BURST: begin
               if (done) begin
                  state   <= IDLE;
                  grant   <= '0;
                  busy    <= 1'b0;
                  af_done <= 1'b0;
                  wd_cnt  <= '0;
                  rr_ptr  <= (gnt_idx == IDX_MAX) ? '0 : gnt_idx + 1'b1;
               end else begin
                  af_done <= af_nxt;
                  wd_cnt  <= cnt_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter (2 engines, 2-word bursts).
// FIFO pushes and grant rises are logged mid-cycle and compared per test.
module tb_gfx_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [61:0]  req_af_addr_din;
   logic [1:0]   req_af_wr_en;
   logic [255:0] req_wdf_din;
   logic [31:0]  req_wdf_mask_din;
   logic [1:0]   req_wdf_wr_en;
   logic [1:0]   req_af_full;
   logic [1:0]   req_wdf_full;
   logic         af_full;
   logic         wdf_full;
   logic [30:0]  af_addr_din;
   logic         af_wr_en;
   logic [127:0] wdf_din;
   logic [15:0]  wdf_mask_din;
   logic         wdf_wr_en;
   logic [1:0]   grant;
   logic         busy;

   int n_checks;
   int n_errors;

   logic [30:0]  af_q[$];
   logic [127:0] wdf_q[$];
   logic [15:0]  msk_q[$];
   logic [1:0]   gnt_q[$];
   logic [1:0]   prev_gnt;

   always #5 clk = ~clk;

   gfx_mem_arbiter #(
      .NUM_REQ(2),
      .ADDR_W(31),
      .BURST_WORDS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_af_addr_din(req_af_addr_din),
      .req_af_wr_en(req_af_wr_en),
      .req_wdf_din(req_wdf_din),
      .req_wdf_mask_din(req_wdf_mask_din),
      .req_wdf_wr_en(req_wdf_wr_en),
      .req_af_full(req_af_full),
      .req_wdf_full(req_wdf_full),
      .af_full(af_full),
      .wdf_full(wdf_full),
      .af_addr_din(af_addr_din),
      .af_wr_en(af_wr_en),
      .wdf_din(wdf_din),
      .wdf_mask_din(wdf_mask_din),
      .wdf_wr_en(wdf_wr_en),
      .grant(grant),
      .busy(busy)
   );

   always @(negedge clk) begin
      if (rst) begin
         if (af_wr_en && !af_full) af_q.push_back(af_addr_din);
         if (wdf_wr_en && !wdf_full) begin
            wdf_q.push_back(wdf_din);
            msk_q.push_back(wdf_mask_din);
         end
         if (grant != 2'b00 && prev_gnt == 2'b00) gnt_q.push_back(grant);
         prev_gnt = grant;
      end else begin
         prev_gnt = 2'b00;
      end
   end

   function automatic logic [30:0] addr_of(int i, int b);
      return 31'h0400_0010 + 31'(i * 'h100) + 31'(b * 'h20);
   endfunction

   function automatic logic [127:0] word_of(int i, int b, int w);
      return {96'hA5A5_0000_1234_5678_9ABC_DEF0,
              8'(i), 8'(b), 8'(w), 8'h5A};
   endfunction

   function automatic logic [15:0] mask_of(int i, int b, int w);
      return 16'(i * 64 + b * 4 + w + 1);
   endfunction

   task automatic set_eng(int i, int b, int w,
                          logic v, logic ae, logic we);
      req_valid[i]                = v;
      req_af_wr_en[i]             = ae;
      req_wdf_wr_en[i]            = we;
      req_af_addr_din[i*31 +: 31] = addr_of(i, b);
      req_wdf_din[i*128 +: 128]   = word_of(i, b, w);
      req_wdf_mask_din[i*16 +: 16] = mask_of(i, b, w);
   endtask

   task automatic clear_inputs();
      req_valid        = '0;
      req_af_wr_en     = '0;
      req_wdf_wr_en    = '0;
      req_af_addr_din  = '0;
      req_wdf_din      = '0;
      req_wdf_mask_din = '0;
      af_full          = 1'b0;
      wdf_full         = 1'b0;
   endtask

   task automatic clear_q();
      af_q.delete();
      wdf_q.delete();
      msk_q.delete();
      gnt_q.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_eng(0, 0, 0, 1'b1, 1'b1, 1'b1);
      set_eng(1, 1, 1, 1'b1, 1'b1, 1'b1);
      #2;
      n_checks++;
      if (grant !== 2'b00) begin
         n_errors++;
         $display("FAIL rst_grant got %b want 00", grant);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_busy got %b want 0", busy);
      end
      n_checks++;
      if ({af_wr_en, wdf_wr_en} !== 2'b00) begin
         n_errors++;
         $display("FAIL rst_en got %b want 00", {af_wr_en, wdf_wr_en});
      end
      n_checks++;
      if ({req_af_full, req_wdf_full} !== 4'b1111) begin
         n_errors++;
         $display("FAIL rst_full got %b want 1111",
                  {req_af_full, req_wdf_full});
      end
      n_checks++;
      if (af_addr_din !== 31'd0 || wdf_din !== 128'd0 ||
          wdf_mask_din !== 16'd0) begin
         n_errors++;
         $display("FAIL rst_data got %h/%h/%h want 0",
                  af_addr_din, wdf_din, wdf_mask_din);
      end
      repeat (2) @(posedge clk);
      #1;
      clear_inputs();
      rst = 1'b1;
      mid();
      n_checks++;
      if (grant !== 2'b00) begin
         n_errors++;
         $display("FAIL rst_idle_grant got %b want 00", grant);
      end
   endtask

   task automatic test_single();
      do_reset();
      clear_q();
      set_eng(0, 0, 0, 1'b1, 1'b1, 1'b1);
      mid();
      n_checks++;
      if (grant !== 2'b00 || af_wr_en !== 1'b0 ||
          req_af_full !== 2'b11) begin
         n_errors++;
         $display("FAIL single_c0 got g=%b en=%b f=%b want 00/0/11",
                  grant, af_wr_en, req_af_full);
      end
      tick();
      mid();
      n_checks++;
      if (grant !== 2'b01 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL single_grant got %b/%b want 01/1", grant, busy);
      end
      n_checks++;
      if (af_wr_en !== 1'b1 || af_addr_din !== 31'h0400_0010 ||
          wdf_wr_en !== 1'b1 || wdf_din !== word_of(0, 0, 0)) begin
         n_errors++;
         $display("FAIL single_pass got %b %h %b %h want 1 04000010 1 %h",
                  af_wr_en, af_addr_din, wdf_wr_en, wdf_din,
                  word_of(0, 0, 0));
      end
      tick();
      set_eng(0, 0, 1, 1'b1, 1'b0, 1'b1);
      mid();
      n_checks++;
      if (req_af_full[0] !== 1'b1 || wdf_wr_en !== 1'b1 ||
          wdf_din !== word_of(0, 0, 1)) begin
         n_errors++;
         $display("FAIL single_w1 got %b %b %h want 1 1 %h",
                  req_af_full[0], wdf_wr_en, wdf_din, word_of(0, 0, 1));
      end
      tick();
      clear_inputs();
      mid();
      n_checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_end got %b/%b want 00/0", grant, busy);
      end
      n_checks++;
      if (af_q.size() != 1 || af_q[0] !== 31'h0400_0010) begin
         n_errors++;
         $display("FAIL single_afq got n=%0d want 1 x 04000010",
                  af_q.size());
      end
      n_checks++;
      if (wdf_q.size() != 2 || wdf_q[0] !== word_of(0, 0, 0) ||
          wdf_q[1] !== word_of(0, 0, 1) ||
          msk_q[1] !== mask_of(0, 0, 1)) begin
         n_errors++;
         $display("FAIL single_wdfq got n=%0d want 2 words A,B",
                  wdf_q.size());
      end
   endtask

   task automatic test_simultaneous();
      int left[2];
      int bidx[2];
      int ws[2];
      bit afs[2];
      bit dra[2];
      bit drw[2];
      bit fa[2];
      bit fw[2];
      int cyc;
      do_reset();
      clear_q();
      for (int i = 0; i < 2; i++) begin
         left[i] = 3;
         bidx[i] = 0;
         ws[i]   = 0;
         afs[i]  = 1'b0;
      end
      cyc = 0;
      while ((left[0] > 0 || left[1] > 0) && cyc < 80) begin
         for (int i = 0; i < 2; i++) begin
            if (left[i] > 0) begin
               dra[i] = !afs[i];
               drw[i] = (ws[i] < 2);
               set_eng(i, bidx[i], ws[i], 1'b1, dra[i], drw[i]);
            end else begin
               dra[i] = 1'b0;
               drw[i] = 1'b0;
               set_eng(i, 0, 0, 1'b0, 1'b0, 1'b0);
            end
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            fa[i] = req_af_full[i];
            fw[i] = req_wdf_full[i];
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            if (dra[i] && !fa[i]) afs[i] = 1'b1;
            if (drw[i] && !fw[i]) ws[i]++;
            if (left[i] > 0 && afs[i] && ws[i] == 2) begin
               left[i]--;
               bidx[i]++;
               afs[i] = 1'b0;
               ws[i]  = 0;
            end
         end
         cyc++;
      end
      clear_inputs();
      mid();
      n_checks++;
      if (cyc >= 80) begin
         n_errors++;
         $display("FAIL simul_timeout got %0d cycles want <80", cyc);
      end
      n_checks++;
      if (gnt_q.size() != 6) begin
         n_errors++;
         $display("FAIL simul_ngrants got %0d want 6", gnt_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (gnt_q[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_errors++;
            $display("FAIL simul_grant%0d got %b want %b", k, gnt_q[k],
                     (k % 2 == 0) ? 2'b01 : 2'b10);
         end
      end
      n_checks++;
      if (af_q.size() != 6 || wdf_q.size() != 12) begin
         n_errors++;
         $display("FAIL simul_counts got %0d/%0d want 6/12",
                  af_q.size(), wdf_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (af_q[k] !== addr_of(k % 2, k / 2) ||
             wdf_q[2*k] !== word_of(k % 2, k / 2, 0) ||
             wdf_q[2*k+1] !== word_of(k % 2, k / 2, 1)) begin
            n_errors++;
            $display("FAIL simul_burst%0d got %h %h %h want %h",
                     k, af_q[k], wdf_q[2*k], wdf_q[2*k+1],
                     addr_of(k % 2, k / 2));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      clear_q();
      set_eng(1, 0, 0, 1'b1, 1'b1, 1'b1);
      tick();
      mid();
      n_checks++;
      if (grant !== 2'b10 || req_af_full !== 2'b01) begin
         n_errors++;
         $display("FAIL bp_grant got %b/%b want 10/01", grant, req_af_full);
      end
      tick();
      wdf_full = 1'b1;
      set_eng(1, 0, 1, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         mid();
         n_checks++;
         if (req_wdf_full[1] !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_stall%0d got %b/%b want 1/1",
                     c, req_wdf_full[1], busy);
         end
         tick();
      end
      wdf_full = 1'b0;
      mid();
      n_checks++;
      if (req_wdf_full[1] !== 1'b0 || wdf_wr_en !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_release got %b/%b want 0/1",
                  req_wdf_full[1], wdf_wr_en);
      end
      tick();
      clear_inputs();
      mid();
      n_checks++;
      if (grant !== 2'b00) begin
         n_errors++;
         $display("FAIL bp_end got %b want 00", grant);
      end
      n_checks++;
      if (af_q.size() != 1 || wdf_q.size() != 2 ||
          wdf_q[1] !== word_of(1, 0, 1)) begin
         n_errors++;
         $display("FAIL bp_stream got %0d/%0d want 1/2",
                  af_q.size(), wdf_q.size());
      end
   endtask

   task automatic test_excess();
      int n;
      do_reset();
      clear_q();
      set_eng(0, 1, 0, 1'b1, 1'b1, 1'b0);
      tick();
      n = 0;
      for (int c = 0; c < 4; c++) begin
         mid();
         if (af_wr_en && !af_full) n++;
         tick();
      end
      n_checks++;
      if (n != 1) begin
         n_errors++;
         $display("FAIL excess_afen got %0d want 1", n);
      end
      set_eng(0, 1, 0, 1'b1, 1'b0, 1'b1);
      mid();
      n_checks++;
      if (req_af_full[0] !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL excess_full got %b/%b want 1/1",
                  req_af_full[0], busy);
      end
      tick();
      set_eng(0, 1, 1, 1'b1, 1'b0, 1'b1);
      tick();
      clear_inputs();
      mid();
      n_checks++;
      if (grant !== 2'b00 || af_q.size() != 1 || wdf_q.size() != 2) begin
         n_errors++;
         $display("FAIL excess_end got g=%b af=%0d wdf=%0d want 00/1/2",
                  grant, af_q.size(), wdf_q.size());
      end
   endtask

   task automatic test_nongranted();
      do_reset();
      clear_q();
      set_eng(0, 2, 0, 1'b1, 1'b1, 1'b0);
      tick();
      set_eng(1, 3, 0, 1'b0, 1'b1, 1'b1);
      mid();
      n_checks++;
      if (req_af_full[1] !== 1'b1 || req_wdf_full[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL ng_full got %b/%b want 1/1",
                  req_af_full[1], req_wdf_full[1]);
      end
      n_checks++;
      if (af_addr_din !== addr_of(0, 2) || af_wr_en !== 1'b1 ||
          wdf_wr_en !== 1'b0) begin
         n_errors++;
         $display("FAIL ng_pass got %h %b %b want %h 1 0",
                  af_addr_din, af_wr_en, wdf_wr_en, addr_of(0, 2));
      end
      tick();
      set_eng(1, 3, 0, 1'b0, 1'b0, 1'b0);
      set_eng(0, 2, 0, 1'b1, 1'b0, 1'b1);
      tick();
      set_eng(0, 2, 1, 1'b1, 1'b0, 1'b1);
      tick();
      clear_inputs();
      mid();
      n_checks++;
      if (af_q.size() != 1 || af_q[0] !== addr_of(0, 2) ||
          gnt_q.size() != 1) begin
         n_errors++;
         $display("FAIL ng_afq got n=%0d g=%0d want 1/1",
                  af_q.size(), gnt_q.size());
      end
      n_checks++;
      if (wdf_q.size() != 2 || wdf_q[0] !== word_of(0, 2, 0) ||
          wdf_q[1] !== word_of(0, 2, 1)) begin
         n_errors++;
         $display("FAIL ng_wdfq got n=%0d want 2 engine-0 words",
                  wdf_q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      clear_q();
      set_eng(0, 0, 0, 1'b1, 1'b1, 1'b1);
      tick();
      tick();
      set_eng(0, 0, 1, 1'b1, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (wdf_wr_en !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL rmid_pre got %b/%b want 1/1", wdf_wr_en, busy);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (grant !== 2'b00 || busy !== 1'b0 ||
          af_wr_en !== 1'b0 || wdf_wr_en !== 1'b0) begin
         n_errors++;
         $display("FAIL rmid_async got g=%b b=%b en=%b%b want 00 0 00",
                  grant, busy, af_wr_en, wdf_wr_en);
      end
      n_checks++;
      if (req_wdf_full !== 2'b11) begin
         n_errors++;
         $display("FAIL rmid_full got %b want 11", req_wdf_full);
      end
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_q();
      set_eng(1, 4, 0, 1'b1, 1'b1, 1'b1);
      tick();
      mid();
      n_checks++;
      if (grant !== 2'b10 || af_addr_din !== addr_of(1, 4)) begin
         n_errors++;
         $display("FAIL rmid_regrant got %b %h want 10 %h",
                  grant, af_addr_din, addr_of(1, 4));
      end
      tick();
      set_eng(1, 4, 1, 1'b1, 1'b0, 1'b1);
      tick();
      clear_inputs();
      mid();
      n_checks++;
      if (grant !== 2'b00 || af_q.size() != 1 ||
          af_q[0] !== addr_of(1, 4) || wdf_q.size() != 2) begin
         n_errors++;
         $display("FAIL rmid_end got g=%b af=%0d wdf=%0d want 00/1/2",
                  grant, af_q.size(), wdf_q.size());
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      prev_gnt = 2'b00;
      rst      = 1'b0;
      clear_inputs();
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_excess();
      test_nongranted();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
